alu_flags_pipe: RTL and testbench
=================================

# alu_flags_pipe

Parametrised, two-stage pipelined ALU with a valid/ready handshake and an architectural flag register (sign, zero, carry, parity, overflow). It generalises the team's 16-bit combinational flag adder to a W-bit, eight-operation unit. Add-with-carry and subtract-with-borrow consume the stored carry, so wide operands can be chained word by word. It sits between an operand source and a result consumer, and either side may stall.

## Interface
- W, 16, operand/result width in bits; minimum 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts the beat this cycle.
- in_op  in  3  operation code (alu_pkg::alu_op_t).
- in_x, in_y  in  W  operands.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_result  out  W  result.
- sign, zero, carry, parity, overflow  out  1 each  flag register; it always describes the current out_result.

## Operation
- Opcodes:
  - 000 ADD: x+y.
  - 001 ADC: x+y+C.
  - 010 SUB: x−y.
  - 011 SBB: x−y−C.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 CMP: flags as SUB; result = x.
- C is the carry flag register value at the moment the op is computed.
- Arithmetic is computed at W+1 bits.
  - ADD/ADC: carry = bit W of the sum.
  - SUB/SBB/CMP: carry = borrow, i.e. 1 when the unsigned x < y + C_in.
- Overflow (signed, two's complement):
  - ADD/ADC: operand MSBs equal and result MSB differs.
  - SUB/SBB/CMP: operand MSBs differ and result MSB ≠ x MSB.
- Logic ops force carry = 0 and overflow = 0.
- For all ops: sign = result[W−1]; zero = (result == 0); parity = 1 when the result has an even number of ones.
- Stage 1 registers op/x/y when in_valid && in_ready.
- Stage 2 computes from the stage-1 registers and, on advance, loads out_result and all five flags together.
- Stage 2 advances when stage 1 is full and (!out_valid || out_ready).
- in_ready = !s1_valid || stage-2 advance.
- The flag register changes only on a stage-2 load. Back-to-back ADC/SBB therefore see the carry of the immediately preceding op, with no hazard.
- Reset (asynchronous, any time, including mid-stall):
  - s1_valid = 0, out_valid = 0, out_result = 0, all flags = 0.
  - Beats in flight are discarded.
- After reset is released, in_ready is 1.

## Timing
- Latency: accepted on edge N, out_valid is high after edge N+1 when the output is free.
- Throughput: one op per cycle with out_ready held high.
- Simultaneous output pop and input accept in the same cycle is legal at full rate.
- Stalls:
  - With out_ready low, at most two beats are held (stage 1 and output).
  - in_ready falls combinationally in the cycle both are full.
- While out_valid && !out_ready, out_result and the flags hold stable.
- The consumer is not required to keep out_ready stable; the producer must hold in_* stable while in_valid && !in_ready.

## Configuration
- ALU_SAT_EN defined:
  - On signed overflow, ADD/ADC/SUB/SBB results clamp to the signed max (positive overflow) or the signed min (negative overflow).
  - overflow and carry still report the raw result.
  - sign, zero and parity are taken from the clamped result.
  - CMP is unaffected.
- ALU_SAT_EN undefined: results wrap modulo 2^W.

## Structure
- alu_pkg holds:
  - alu_op_t enum with the eight codes.
  - Flag index constants FLG_S, FLG_Z, FLG_C, FLG_P, FLG_V.
  - The width-independent opcode width constant.
- alu_flags_core is the natural sub-module: a purely combinational W-parameterised op/x/y/c_in → result+flags block, including the saturation logic. alu_flags_pipe holds only the registers and the handshake.

## Test plan
- W=16, ADD 5+5 → result 0x000A, S0 Z0 C0 P1 V0, out_valid two edges after accept.
- ADD 0x7FFF+0x0001 → 0x8000, V1 S1 C0. With ALU_SAT_EN → 0x7FFF, V1 S0.
- ADD 0xFFFF+0x0001, then ADC 0x0000+0x0000 on the next cycle:
  - First op → 0x0000, Z1 C1.
  - Second op → 0x0001, C0.
- SUB 5−7 → 0xFFFE, C1 S1 V0 P0. CMP 3,3 → result 0x0003, Z1 C0.
- Issue three ops with out_ready low:
  - in_ready drops after two accepts; out_result holds stable.
  - Raise out_ready: all three results emerge in order, none lost.
- Assert rst_n low while stalled with two beats held → out_valid, s1_valid and flags go to 0 immediately; after release, in_ready = 1 and the next op completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and flag-index definitions for the pipelined flag ALU.
// Saturating arithmetic is selected per build with the ALU_SAT_EN macro.
package alu_pkg;

  localparam int OP_W = 3;
  localparam int NFLG = 5;

  localparam int FLG_S = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_P = 1;
  localparam int FLG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_SUB = 3'b010,
    OP_SBB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_CMP = 3'b111
  } alu_op_t;

endpackage

// File: rtl/alu_flags_core.sv
// Combinational W-bit ALU: op/x/y/carry-in to result plus S/Z/C/P/V flags.
// Define ALU_SAT_EN to clamp overflowing ADD/ADC/SUB/SBB results.
module alu_flags_core
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  alu_op_t          op_i,
  input  logic [W-1:0]     x_i,
  input  logic [W-1:0]     y_i,
  input  logic             c_i,
  output logic [W-1:0]     result_o,
  output logic [NFLG-1:0]  flags_o
);

  logic [W:0]   add_w;
  logic [W:0]   sub_w;
  logic         cin;
  logic [W-1:0] raw;
  logic [W-1:0] sat;
  logic         carry;
  logic         ovf;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    raw   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    cin   = (op_i == OP_ADC || op_i == OP_SBB) ? c_i : 1'b0;
    add_w = {1'b0, x_i} + {1'b0, y_i} + {{W{1'b0}}, cin};
    sub_w = {1'b0, x_i} - {1'b0, y_i} - {{W{1'b0}}, cin};

    case (op_i)
      OP_ADD, OP_ADC: begin
        raw   = add_w[W-1:0];
        carry = add_w[W];
        ovf   = (x_i[W-1] == y_i[W-1]) && (raw[W-1] != x_i[W-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        raw   = sub_w[W-1:0];
        carry = sub_w[W];  // borrow out of the W+1-bit difference
        ovf   = (x_i[W-1] != y_i[W-1]) && (raw[W-1] != x_i[W-1]);
      end
      OP_AND:  raw = x_i & y_i;
      OP_OR:   raw = x_i | y_i;
      OP_XOR:  raw = x_i ^ y_i;
      default: raw = '0;
    endcase

`ifdef ALU_SAT_EN
    // Overflow direction follows x's sign for both add and subtract.
    if (ovf && op_i != OP_CMP)
      sat = x_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat = raw;
`else
    sat = raw;
`endif

    result_o       = (op_i == OP_CMP) ? x_i : sat;
    flags_o        = '0;
    flags_o[FLG_S] = sat[W-1];
    flags_o[FLG_Z] = (sat == '0);
    flags_o[FLG_C] = carry;
    flags_o[FLG_P] = ~^sat;
    flags_o[FLG_V] = ovf;
  end

endmodule

// File: rtl/alu_flags_pipe.sv
// Two-stage valid/ready ALU pipeline with an architectural flag register.
// Saturation in the datapath is enabled by defining ALU_SAT_EN.
module alu_flags_pipe
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  alu_op_t      in_op,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         sign,
  output logic         zero,
  output logic         carry,
  output logic         parity,
  output logic         overflow
);

  logic            s1_valid_q, s1_valid_d;
  alu_op_t         s1_op_q;
  logic [W-1:0]    s1_x_q, s1_y_q;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_result_q;
  logic [NFLG-1:0] flags_q;

  logic            adv;
  logic            accept;
  logic [W-1:0]    core_result;
  logic [NFLG-1:0] core_flags;

  alu_flags_core #(.W(W)) u_core (
    .op_i     (s1_op_q),
    .x_i      (s1_x_q),
    .y_i      (s1_y_q),
    .c_i      (flags_q[FLG_C]),
    .result_o (core_result),
    .flags_o  (core_flags)
  );

  always_comb begin
    adv      = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || adv;
    accept   = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    if (accept)   s1_valid_d = 1'b1;
    else if (adv) s1_valid_d = 1'b0;

    out_valid_d = out_valid_q;
    if (adv)            out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      flags_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (adv) begin
        out_result_q <= core_result;
        flags_q      <= core_flags;
      end
    end
  end

  // NOTE: stage-1 payload is deliberately unreset; s1_valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op_q <= in_op;
      s1_x_q  <= in_x;
      s1_y_q  <= in_y;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign sign       = flags_q[FLG_S];
  assign zero       = flags_q[FLG_Z];
  assign carry      = flags_q[FLG_C];
  assign parity     = flags_q[FLG_P];
  assign overflow   = flags_q[FLG_V];

endmodule

// File: tb/tb_alu_flags_pipe.sv
// Self-checking bench for alu_flags_pipe (W=16): directed vectors, stall and
// reset sequences, then randomized traffic scored against an arithmetic model.
module tb_alu_flags_pipe;
  import alu_pkg::*;

  localparam int W = 16;
`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   flg;  // {S,Z,C,P,V}
  } exp_t;

  typedef struct {
    alu_op_t      op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] res;
    logic [4:0]   flg;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  alu_op_t      in_op = OP_ADD;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         sign, zero, carry, parity, overflow;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic model_c = 1'b0;
  bit   in_pending = 1'b0;
  exp_t exp_q[$];
  vec_t vecs[$];

  alu_flags_pipe #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .sign       (sign),
    .zero       (zero),
    .carry      (carry),
    .parity     (parity),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(alu_op_t op, logic [W-1:0] x, logic [W-1:0] y, logic c);
    exp_t e;
    int ux, uy, sx, sy, u, s, ci;
    logic [31:0] u32;
    logic [W-1:0] r, fr;
    logic cf, vf;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    ci = (op == OP_ADC || op == OP_SBB) ? int'(c) : 0;
    cf = 1'b0; vf = 1'b0; u = 0; s = 0;
    case (op)
      OP_ADD, OP_ADC: begin u = ux + uy + ci; s = sx + sy + ci; cf = (u > 65535); end
      OP_SUB, OP_SBB, OP_CMP: begin u = ux - uy - ci; s = sx - sy - ci; cf = (u < 0); end
      default: ;
    endcase
    u32 = u;
    r = u32[W-1:0];
    if (op == OP_AND) r = x & y;
    if (op == OP_OR)  r = x | y;
    if (op == OP_XOR) r = x ^ y;
    if (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP}) vf = (s > 32767) || (s < -32768);
    fr = r;
    if (SAT && vf && op != OP_CMP) fr = (s > 0) ? 16'h7FFF : 16'h8000;
    e.res = (op == OP_CMP) ? x : fr;
    e.flg = {fr[W-1], (fr == '0), cf, ~^fr, vf};
    return e;
  endfunction

  // One cycle from a negedge: score outputs, record transfers, advance to next negedge.
  task automatic step(input bit use_ovr, input exp_t ovr);
    exp_t e;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL spurious_out: got result %h with nothing expected", out_result);
      end else begin
        check("result", out_result, exp_q[0].res);
        check("flags", {sign, zero, carry, parity, overflow}, exp_q[0].flg);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    in_pending = in_valid && !in_ready;
    if (in_valid && in_ready) begin
      e = use_ovr ? ovr : model(in_op, in_x, in_y, model_c);
      model_c = e.flg[2];
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input alu_op_t op, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; in_op = op; in_x = x; in_y = y;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  initial begin
    exp_t none;
    exp_t ov;
    none.res = '0; none.flg = '0;

    vecs.push_back('{OP_ADD, 16'h0005, 16'h0005, 16'h000A, 5'b00010});
    vecs.push_back('{OP_ADD, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h8000, SAT ? 5'b00001 : 5'b10001});
    vecs.push_back('{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 5'b01110});
    vecs.push_back('{OP_ADC, 16'h0000, 16'h0000, 16'h0001, 5'b00000});
    vecs.push_back('{OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 5'b10100});
    vecs.push_back('{OP_CMP, 16'h0003, 16'h0003, 16'h0003, 5'b01010});
    vecs.push_back('{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 5'b10110});
    vecs.push_back('{OP_SBB, 16'h0005, 16'h0002, 16'h0002, 5'b00000});
    vecs.push_back('{OP_SBB, 16'h0000, 16'h0000, 16'h0000, 5'b01010});
    vecs.push_back('{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 5'b10010});
    vecs.push_back('{OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 5'b00010});
    vecs.push_back('{OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b01010});
    vecs.push_back('{OP_SUB, 16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, SAT ? 5'b10001 : 5'b00001});
    vecs.push_back('{OP_ADD, 16'h8000, 16'h8000, SAT ? 16'h8000 : 16'h0000, SAT ? 5'b10101 : 5'b01111});
    vecs.push_back('{OP_ADC, 16'h0001, 16'h0001, 16'h0003, 5'b00010});

    // Reset state.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_flags", {sign, zero, carry, parity, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Latency: accept on edge N, result visible after edge N+1.
    @(negedge clk);
    drive(OP_ADD, 16'h0005, 16'h0005);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat_valid_n", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("lat_valid_n1", out_valid, 1);
    check("lat_result", out_result, 16'h000A);
    check("lat_flags", {sign, zero, carry, parity, overflow}, 5'b00010);
    @(posedge clk);
    @(negedge clk);
    model_c = 1'b0;

    // Directed vectors, back to back at full rate.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].x, vecs[i].y);
      ov.res = vecs[i].res; ov.flg = vecs[i].flg;
      step(1'b1, ov);
    end
    in_valid = 1'b0;
    repeat (3) step(1'b0, none);
    check("vec_drain", 32'(exp_q.size()), 0);

    // Stall: three ops with out_ready low, only two may be held.
    out_ready = 1'b0;
    drive(OP_ADD, 16'h0001, 16'h0002); step(1'b0, none);
    drive(OP_SUB, 16'h000A, 16'h0003); step(1'b0, none);
    drive(OP_XOR, 16'h00FF, 16'h000F);
    #1;
    check("stall_in_ready", in_ready, 0);
    repeat (3) step(1'b0, none);
    check("stall_held", 32'(exp_q.size()), 2);
    out_ready = 1'b1;
    step(1'b0, none);
    in_valid = 1'b0;
    repeat (3) step(1'b0, none);
    check("stall_drain", 32'(exp_q.size()), 0);

    // Reset while two beats are held.
    out_ready = 1'b0;
    drive(OP_ADD, 16'hFFFF, 16'h0001); step(1'b0, none);
    drive(OP_ADD, 16'h1111, 16'h2222); step(1'b0, none);
    in_valid = 1'b0;
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_carry", carry, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_flags", {sign, zero, carry, parity, overflow}, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    model_c = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(OP_ADC, 16'h0002, 16'h0003);
    step(1'b0, none);
    in_valid = 1'b0;
    repeat (3) step(1'b0, none);
    check("post_rst_drain", 32'(exp_q.size()), 0);

    // Randomized traffic with random back-pressure.
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!in_pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = alu_op_t'($urandom_range(0, 7));
        in_x     = pick();
        in_y     = pick();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step(1'b0, none);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, none);
    check("rand_drain", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
